// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: per-channel synchronizer chain, debounce filter,
// edge detector and sticky event flag, with an OR-reduced interrupt.

module sync_filter_lane #(
   parameter int stages        = 2,
   parameter int filter_cycles = 4,
   parameter int edge_mode     = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din_i,
   input  logic clear_i,
   output logic dout_o,
   output logic rise_o,
   output logic fall_o,
   output logic flag_o
);
   localparam int CW = $clog2(filter_cycles + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(filter_cycles - 1);

   logic [stages-1:0] sync_q;
   logic              sync;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              dout_q, dout_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              flag_q, flag_d;
   logic              set_evt;

   assign sync = sync_q[stages-1];

   // Only a value that differs from dout for filter_cycles consecutive cycles
   // is accepted; any return to the current level restarts the count.
   always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (sync == dout_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d  = '0;
         dout_d = sync;
         rise_d = sync;
         fall_d = ~sync;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // A new event beats a same-cycle clear so no edge is ever lost.
   always_comb begin
      set_evt = (rise_q && (edge_mode != 2)) || (fall_q && (edge_mode != 1));
      if (set_evt)      flag_d = 1'b1;
      else if (clear_i) flag_d = 1'b0;
      else              flag_d = flag_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         dout_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[stages-2:0], din_i};
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
      end
   end

   assign dout_o = dout_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign flag_o = flag_q;

   a_edge_excl : assert property (@(posedge clock) disable iff (!reset_n) !(rise_q && fall_q));
   a_cnt_bound : assert property (@(posedge clock) disable iff (!reset_n) cnt_q <= CNT_LAST);
endmodule

module sync_filter_bank #(
   parameter int channels      = 8,
   parameter int stages        = 2,
   parameter int filter_cycles = 4,
   parameter int edge_mode     = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [channels-1:0] din,
   input  logic [channels-1:0] clear,
   output logic [channels-1:0] dout,
   output logic [channels-1:0] rise,
   output logic [channels-1:0] fall,
   output logic [channels-1:0] event_flags,
   output logic                irq
);
   sync_filter_lane #(
      .stages        (stages),
      .filter_cycles (filter_cycles),
      .edge_mode     (edge_mode)
   ) u_lane [channels-1:0] (
      .clock   (clock),
      .reset_n (reset_n),
      .din_i   (din),
      .clear_i (clear),
      .dout_o  (dout),
      .rise_o  (rise),
      .fall_o  (fall),
      .flag_o  (event_flags)
   );

   assign irq = |event_flags;
endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank: one instance in both-edge mode, one in falling-only mode.

module tb_sync_filter_bank;
   logic       clock;
   logic       reset_n;
   logic [7:0] din, clear;
   logic [7:0] dout, rise, fall, flags;
   logic       irq;
   logic [7:0] dout2, rise2, fall2, flags2;
   logic       irq2;

   int total = 0;
   int bad   = 0;

   sync_filter_bank #(.channels(8), .stages(2), .filter_cycles(4), .edge_mode(0)) dut (
      .clock(clock), .reset_n(reset_n), .din(din), .clear(clear),
      .dout(dout), .rise(rise), .fall(fall), .event_flags(flags), .irq(irq));

   sync_filter_bank #(.channels(8), .stages(2), .filter_cycles(4), .edge_mode(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .din(din), .clear(clear),
      .dout(dout2), .rise(rise2), .fall(fall2), .event_flags(flags2), .irq(irq2));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one posedge; inputs are driven and outputs sampled 1ns later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clean(input string tag);
      din = '0;
      repeat (8) tick();
      clear = '1;
      tick();
      clear = '0;
      chk({tag, "_flags_clr"}, flags, 8'h00);
      chk({tag, "_flags2_clr"}, flags2, 8'h00);
      chk({tag, "_irq_clr"}, irq, 1'b0);
   endtask

   logic [8:0] seq;
   logic       acc;
   int         nrise, rise_at;

   initial begin
      reset_n = 1'b1;
      din     = 8'hFF;
      clear   = '0;
      #1 reset_n = 1'b0;

      // 1: reset state, then release with all inputs high
      repeat (2) tick();
      chk("rst_dout", dout, 8'h00);
      chk("rst_rise", rise, 8'h00);
      chk("rst_fall", fall, 8'h00);
      chk("rst_flags", flags, 8'h00);
      chk("rst_irq", irq, 1'b0);
      reset_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) chk("t1_dout_e5", dout, 8'h00);
         if (e == 6) begin
            chk("t1_dout_e6", dout, 8'hFF);
            chk("t1_rise_e6", rise, 8'hFF);
            chk("t1_flags_e6", flags, 8'h00);
         end
         if (e == 7) begin
            chk("t1_rise_e7", rise, 8'h00);
            chk("t1_flags_e7", flags, 8'hFF);
            chk("t1_irq_e7", irq, 1'b1);
            chk("t1_flags2_e7", flags2, 8'h00);
         end
      end
      clean("t1");

      // 2: 3-cycle glitch is rejected, 4-cycle pulse is accepted
      din[0] = 1'b1;
      repeat (3) tick();
      din[0] = 1'b0;
      acc = 1'b0;
      for (int e = 0; e < 8; e++) begin
         tick();
         acc = acc | dout[0] | rise[0] | flags[0];
      end
      chk("t2_glitch", acc, 1'b0);
      din[0] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 4) din[0] = 1'b0;
         if (e == 5) chk("t2_dout_e5", dout[0], 1'b0);
         if (e == 6) begin
            chk("t2_dout_e6", dout[0], 1'b1);
            chk("t2_rise_e6", rise[0], 1'b1);
         end
      end
      clean("t2");

      // 3: bouncing input yields one rise, 6 edges after the final run starts
      seq = 9'b1_1110_1101;  // bit k = value before edge k+1
      nrise = 0;
      rise_at = 0;
      for (int e = 1; e <= 16; e++) begin
         if (e <= 9) din[3] = seq[e-1];
         tick();
         if (rise[3]) begin
            nrise++;
            rise_at = e;
         end
      end
      chk("t3_nrise", nrise, 1);
      chk("t3_rise_edge", rise_at, 11);
      clean("t3");

      // 4: falling-only mode ignores the rise, latches the fall
      din[5] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         if (e == 6) chk("t4_rise2", rise2[5], 1'b1);
         if (e == 7) begin
            chk("t4_flag2_after_rise", flags2[5], 1'b0);
            chk("t4_irq2_after_rise", irq2, 1'b0);
            chk("t4_flag_mode0", flags[5], 1'b1);
         end
      end
      din[5] = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 6) chk("t4_fall2", fall2[5], 1'b1);
         if (e == 7) begin
            chk("t4_flag2_after_fall", flags2[5], 1'b1);
            chk("t4_irq2", irq2, 1'b1);
         end
      end
      clean("t4");

      // 5: clear colliding with a new fall loses; clear alone wins
      din[1] = 1'b1;
      repeat (8) tick();
      chk("t5_flag_set", flags[1], 1'b1);
      din[1] = 1'b0;
      repeat (6) tick();
      chk("t5_fall", fall[1], 1'b1);
      clear[1] = 1'b1;
      tick();
      chk("t5_collide", flags[1], 1'b1);
      tick();
      chk("t5_cleared", flags, 8'h00);
      chk("t5_irq", irq, 1'b0);
      chk("t5_irq2", irq2, 1'b0);
      clear[1] = 1'b0;
      clean("t5");

      // 6: async reset mid-count, then full latency from release
      din[7] = 1'b1;
      repeat (8) tick();
      chk("t6_pre_flags", flags, 8'h80);
      din[2] = 1'b1;
      repeat (4) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_dout", dout, 8'h00);
      chk("t6_rst_flags", flags, 8'h00);
      chk("t6_rst_irq", irq, 1'b0);
      tick();
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 5) chk("t6_dout_e5", dout, 8'h00);
         if (e == 6) begin
            chk("t6_dout_e6", dout, 8'h84);
            chk("t6_rise_e6", rise, 8'h84);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
